secuenciador: RTL
=================

SECUENCIADOR -- requirements
Module: secuenciador

Interface
REQ-001 The block SHALL use exactly one clock and an asynchronous, active-low reset, with ports in this order: ck, rst_n.
REQ-002 ck  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 pc  input  4  current program counter from the program-counter block.
REQ-005 run  input  1  level; 1 = execute program, 0 = stop after the current instruction.
REQ-006 cond  input  1  external test bit, sampled in FETCH.
REQ-007 ld_we  input  1  program-memory write strobe.
REQ-008 ld_addr  input  4  program-memory write address.
REQ-009 ld_data  input  8  program-memory write data.
REQ-010 opc  output  3  opcode to the program-counter block.
REQ-011 dir  output  4  jump target to the program-counter block.
REQ-012 x  output  1  condition flag to the program-counter block.
REQ-013 fase  output  2  state encoding: IDLE=00, FETCH=01, EXEC=10, HALT=11.
REQ-014 retired  output  8  count of executed non-halt instructions.

Function
REQ-015 Program memory SHALL be 16 x 8 bits; word format: [7] halt flag, [6:4] opc, [3:0] dir.
REQ-016 Hold code SHALL be opc=111, dir=0000; the program-counter block keeps pc for this code regardless of x.
REQ-017 opc/dir SHALL carry the hold code in every state except EXEC.
REQ-018 IDLE: run=1 -> FETCH next cycle; run=0 -> stay in IDLE.
REQ-019 FETCH (1 cycle): IR <= mem[pc]; xr <= cond; -> EXEC.
REQ-020 EXEC (1 cycle), IR[7]=0: opc=IR[6:4], dir=IR[3:0], retired <= retired+1 (mod 256); -> FETCH if run=1, else IDLE.
REQ-021 EXEC, IR[7]=1: opc/dir SHALL carry the hold code, retired unchanged; -> HALT.
REQ-022 HALT: run=0 -> IDLE; run=1 -> stay in HALT.
REQ-023 x SHALL equal xr in all states, so it is stable across the EXEC edge on which pc updates.
REQ-024 Each instruction SHALL take exactly 2 cycles (FETCH+EXEC); pc changes only at the end of EXEC.
REQ-025 ld_we SHALL write mem[ld_addr] <= ld_data only in IDLE or HALT; writes in FETCH/EXEC SHALL be ignored.
REQ-026 ld_we with run=1 in IDLE: the write SHALL complete, and the following FETCH SHALL read the updated contents.
REQ-027 run dropping during FETCH SHALL NOT abort; the EXEC SHALL complete, then -> IDLE.
REQ-028 retired SHALL wrap 255 -> 0 with no saturation.

Reset
REQ-029 On rst_n=0, immediately and independent of ck: fase=IDLE, IR=8'h70 (hold), xr=0, opc=111, dir=0000, x=0, retired=0.
REQ-030 Reset SHALL NOT clear program memory; contents SHALL survive reset.
REQ-031 Reset asserted during EXEC SHALL force the hold code in the same cycle, so pc is not updated by the aborted instruction.
REQ-032 After rst_n rises, the block SHALL remain in IDLE until the first ck edge with run=1.

Verification
REQ-033 Load mem[0]=8'h00, mem[1]=8'h25, run=1, cond=1, pc=0 -> FETCH then EXEC opc=000, x=1; with pc=1 next: EXEC opc=010, dir=5, x=1, retired=2.
REQ-034 mem[3]=8'h80 (halt), pc=3, run=1 -> FETCH, EXEC with opc=111, then fase=11 held; run=0 -> fase=00; retired unchanged.
REQ-035 ld_we=1, ld_addr=2, ld_data=8'h3A during EXEC -> mem[2] unchanged; the same write in IDLE -> mem[2]=8'h3A, and the next FETCH at pc=2 gives opc=011, dir=A.
REQ-036 rst_n pulsed low mid-EXEC -> opc=111, x=0, fase=00, retired=0 asynchronously; memory readback unchanged.
REQ-037 Run 256 non-halt instructions -> retired wraps to 0; run dropped in FETCH -> one more EXEC, then IDLE.
REQ-038 cond toggled during EXEC -> x holds the value sampled in FETCH.

Source files
------------

// File: rtl/secuenciador.sv
// secuenciador: two-phase (FETCH/EXEC) instruction sequencer with a 16x8
// program memory. It drives opc/dir/x to an external program-counter block
// and counts retired non-halt instructions.
module secuenciador (
    input  logic       ck,
    input  logic       rst_n,
    input  logic [3:0] pc,
    input  logic       run,
    input  logic       cond,
    input  logic       ld_we,
    input  logic [3:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic [2:0] opc,
    output logic [3:0] dir,
    output logic       x,
    output logic [1:0] fase,
    output logic [7:0] retired
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        HALT  = 2'b11
    } state_t;

    // The hold word decodes to opc=111, dir=0000, so the program counter
    // keeps its value whatever x says.
    localparam logic [7:0] HOLD_WORD = 8'h70;
    localparam logic [2:0] HOLD_OPC  = 3'b111;
    localparam logic [3:0] HOLD_DIR  = 4'b0000;

    state_t     r_state;
    logic [7:0] r_ir;
    logic       r_xr;
    logic [7:0] r_retired;
    logic [7:0] r_mem [16];

    logic       w_loadOk;
    logic       w_execActive;

    // Loading is only safe while no instruction is in flight.
    assign w_loadOk     = (r_state == IDLE) || (r_state == HALT);

    // Only a non-halt instruction in EXEC may present its own opc/dir.
    assign w_execActive = (r_state == EXEC) && !r_ir[7];

    // Program memory write port; it has no reset so a program survives rst_n.
    always_ff @(posedge ck) begin
        if (ld_we && w_loadOk) begin
            r_mem[ld_addr] <= ld_data;
        end
    end

    // Sequencer state, instruction register, sampled condition and retire count.
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_ir      <= HOLD_WORD;
            r_xr      <= 1'b0;
            r_retired <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_state <= FETCH;
                    end
                end
                FETCH: begin
                    r_ir    <= r_mem[pc];
                    r_xr    <= cond;
                    r_state <= EXEC;
                end
                EXEC: begin
                    if (r_ir[7]) begin
                        r_state <= HALT;
                    end else begin
                        r_retired <= r_retired + 8'd1;
                        r_state   <= run ? FETCH : IDLE;
                    end
                end
                HALT: begin
                    if (!run) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // opc/dir are decoded from registered state only, so an asynchronous
    // reset during EXEC falls back to the hold code in that same cycle.
    assign opc     = w_execActive ? r_ir[6:4] : HOLD_OPC;
    assign dir     = w_execActive ? r_ir[3:0] : HOLD_DIR;

    // x comes straight from the FETCH sample so it cannot move while the
    // program counter consumes it at the end of EXEC.
    assign x       = r_xr;
    assign fase    = r_state;
    assign retired = r_retired;

endmodule
